// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter_pkg
//  Purpose  : Shared types and constants for the dual-port async SRAM arbiter.
//             Holds the per-half SRAM cycle state encodings, the controller
//             state encodings, half selectors and the strobe-inactive level.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    // One 16-bit SRAM cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    // Word-level controller wrapped around the half-word cycles.
    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_RUN  = 2'd1,
        CTL_DONE = 2'd2
    } ctl_state_t;

    localparam logic c_half_lo    = 1'b0;
    localparam logic c_half_hi    = 1'b1;
    localparam logic c_strobe_off = 1'b1;   // SRAM strobes are active-low

    // Byte enables (active-high) belonging to one half of a 32-bit word.
    function automatic logic [1:0] half_be(input logic [3:0] mask, input logic half);
        return half ? mask[3:2] : mask[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_half_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sram_half_seq
//  Purpose  : Runs one 16-bit async SRAM cycle: SETUP (1 cycle), ACCESS
//             (WAIT_CYCLES+1 cycles), HOLD (writes only, 1 cycle). All pin
//             outputs are registered from the next state so they change on
//             the same edge the state does.
//  Ports    : CLK, reset_in (sync, active-low); i_start launches a cycle using
//             i_write/i_addr/i_wdata/i_be; o_half_end flags the final cycle of
//             the current half; o_rd_stb pulses the cycle after o_rdata loads;
//             o_sram_* drive the SRAM pins / pad output enable.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_half_seq
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              CLK,
    input  logic              reset_in,
    input  logic              i_start,
    input  logic              i_write,
    input  logic [ADDR_W:0]   i_addr,
    input  logic [15:0]       i_wdata,
    input  logic [1:0]        i_be,
    input  logic [15:0]       i_dat_read,
    output logic              o_half_end,
    output logic              o_rd_stb,
    output logic [15:0]       o_rdata,
    output logic [ADDR_W:0]   o_sram_addr,
    output logic [15:0]       o_sram_dat_write,
    output logic              o_sram_dat_oe,
    output logic              o_sram_cs,
    output logic              o_sram_we,
    output logic              o_sram_oe,
    output logic              o_sram_lb,
    output logic              o_sram_ub
);

    localparam int c_CNT_W = $clog2(WAIT_CYCLES + 1) + 1;

    seq_state_t           r_state, w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_write;
    logic [1:0]           r_be;
    logic                 w_write;
    logic [1:0]           w_be;
    logic                 w_sample;
    logic [ADDR_W:0]      w_addr;
    logic [15:0]          w_dat;
    logic                 w_dat_oe, w_cs, w_we, w_oe, w_lb, w_ub;

    // On the launch edge the command has not been latched yet, so pins come
    // straight from the inputs; afterwards from the latched copy.
    assign w_write  = i_start ? i_write : r_write;
    assign w_be     = i_start ? i_be    : r_be;
    assign w_sample = (r_state == ACCESS) && (r_cnt == '0) && !r_write;

    always_comb begin
        w_next     = r_state;
        o_half_end = 1'b0;
        case (r_state)
            SETUP:  w_next = ACCESS;
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_next     = r_write ? HOLD : IDLE;
                    o_half_end = !r_write;
                end
            end
            HOLD: begin
                w_next     = IDLE;
                o_half_end = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        if (i_start) begin
            w_next = SETUP;
        end
    end

    always_comb begin
        w_addr   = o_sram_addr;
        w_dat    = o_sram_dat_write;
        w_dat_oe = 1'b0;
        w_cs     = c_strobe_off;
        w_we     = c_strobe_off;
        w_oe     = c_strobe_off;
        w_lb     = c_strobe_off;
        w_ub     = c_strobe_off;
        case (w_next)
            SETUP: begin
                w_addr   = i_addr;
                w_cs     = 1'b0;
                w_oe     = w_write;
                w_dat_oe = w_write;
                if (w_write) begin
                    w_dat = i_wdata;
                end
            end
            ACCESS: begin
                w_cs     = 1'b0;
                w_oe     = w_write;
                w_we     = !w_write;
                w_dat_oe = w_write;
                w_lb     = w_write ? !w_be[0] : 1'b0;
                w_ub     = w_write ? !w_be[1] : 1'b0;
            end
            HOLD: begin
                w_cs     = 1'b0;
                w_dat_oe = 1'b1;
                w_lb     = !w_be[0];
                w_ub     = !w_be[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset_in) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_write          <= 1'b0;
            r_be             <= 2'b00;
            o_rd_stb         <= 1'b0;
            o_rdata          <= '0;
            o_sram_addr      <= '0;
            o_sram_dat_write <= '0;
            o_sram_dat_oe    <= 1'b0;
            o_sram_cs        <= c_strobe_off;
            o_sram_we        <= c_strobe_off;
            o_sram_oe        <= c_strobe_off;
            o_sram_lb        <= c_strobe_off;
            o_sram_ub        <= c_strobe_off;
        end else begin
            r_state          <= w_next;
            o_sram_addr      <= w_addr;
            o_sram_dat_write <= w_dat;
            o_sram_dat_oe    <= w_dat_oe;
            o_sram_cs        <= w_cs;
            o_sram_we        <= w_we;
            o_sram_oe        <= w_oe;
            o_sram_lb        <= w_lb;
            o_sram_ub        <= w_ub;
            if (i_start) begin
                r_write <= i_write;
                r_be    <= i_be;
            end
            // Counter reloads in SETUP, so it never needs to wrap.
            if (r_state == SETUP) begin
                r_cnt <= c_CNT_W'(WAIT_CYCLES);
            end else if (r_state == ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            o_rd_stb <= w_sample;
            if (w_sample) begin
                o_rdata <= i_dat_read;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Round-robin share of a 256Kx16 async SRAM between two 32-bit
//             word requesters. Each word is split into two 16-bit SRAM cycles
//             (low half first); write halves with no enabled bytes are skipped.
//  Ports    : io_mainClk / io_resetn (sync, active-low); io_p0_* and io_p1_*
//             command (valid/ready/write/addr/data/mask) and read response
//             (rsp_valid pulse, rsp_data); io_sram_* registered SRAM pins and
//             pad output enable.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              io_mainClk,
    input  logic              io_resetn,
    input  logic              io_p0_cmd_valid,
    output logic              io_p0_cmd_ready,
    input  logic              io_p0_cmd_write,
    input  logic [ADDR_W-1:0] io_p0_cmd_addr,
    input  logic [31:0]       io_p0_cmd_data,
    input  logic [3:0]        io_p0_cmd_mask,
    output logic              io_p0_rsp_valid,
    output logic [31:0]       io_p0_rsp_data,
    input  logic              io_p1_cmd_valid,
    output logic              io_p1_cmd_ready,
    input  logic              io_p1_cmd_write,
    input  logic [ADDR_W-1:0] io_p1_cmd_addr,
    input  logic [31:0]       io_p1_cmd_data,
    input  logic [3:0]        io_p1_cmd_mask,
    output logic              io_p1_rsp_valid,
    output logic [31:0]       io_p1_rsp_data,
    output logic [ADDR_W:0]   io_sram_addr,
    input  logic [15:0]       io_sram_dat_read,
    output logic [15:0]       io_sram_dat_write,
    output logic              io_sram_dat_writeEnable,
    output logic              io_sram_cs,
    output logic              io_sram_we,
    output logic              io_sram_oe,
    output logic              io_sram_lb,
    output logic              io_sram_ub
);

    ctl_state_t          r_ctl, w_ctl_next;
    logic                r_last_grant, r_port, r_write, r_half;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic [3:0]          r_mask;
    logic [15:0]         r_lo;

    logic                w_idle, w_grant, w_accept, w_more;
    logic                w_sel_write, w_sel_lo_en, w_sel_hi_en, w_first_half;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_data;
    logic [3:0]          w_sel_mask;
    logic                w_start, w_seq_write;
    logic [ADDR_W:0]     w_seq_addr;
    logic [15:0]         w_seq_wdata;
    logic [1:0]          w_seq_be;
    logic                w_half_end, w_rd_stb;
    logic [15:0]         w_rdata;

    // Lone requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        if (io_p0_cmd_valid && io_p1_cmd_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = io_p1_cmd_valid;
        end
    end

    assign w_idle          = (r_ctl == CTL_IDLE);
    assign io_p0_cmd_ready = w_idle && !w_grant;
    assign io_p1_cmd_ready = w_idle &&  w_grant;
    assign w_accept        = (io_p0_cmd_valid && io_p0_cmd_ready) ||
                             (io_p1_cmd_valid && io_p1_cmd_ready);

    assign w_sel_write  = w_grant ? io_p1_cmd_write : io_p0_cmd_write;
    assign w_sel_addr   = w_grant ? io_p1_cmd_addr  : io_p0_cmd_addr;
    assign w_sel_data   = w_grant ? io_p1_cmd_data  : io_p0_cmd_data;
    assign w_sel_mask   = w_grant ? io_p1_cmd_mask  : io_p0_cmd_mask;
    assign w_sel_lo_en  = !w_sel_write || (|w_sel_mask[1:0]);
    assign w_sel_hi_en  = !w_sel_write || (|w_sel_mask[3:2]);
    assign w_first_half = w_sel_lo_en ? c_half_lo : c_half_hi;

    // A high half still follows only when the low half just ran and needs it.
    assign w_more = (r_half == c_half_lo) && (!r_write || (|r_mask[3:2]));

    always_comb begin
        if (w_idle) begin
            w_start     = w_accept && (w_sel_lo_en || w_sel_hi_en);
            w_seq_write = w_sel_write;
            w_seq_addr  = {w_sel_addr, w_first_half};
            w_seq_wdata = w_first_half ? w_sel_data[31:16] : w_sel_data[15:0];
            w_seq_be    = half_be(w_sel_mask, w_first_half);
        end else begin
            w_start     = (r_ctl == CTL_RUN) && w_half_end && w_more;
            w_seq_write = r_write;
            w_seq_addr  = {r_addr, c_half_hi};
            w_seq_wdata = r_data[31:16];
            w_seq_be    = r_mask[3:2];
        end
    end

    always_comb begin
        w_ctl_next = r_ctl;
        case (r_ctl)
            CTL_IDLE: if (w_start)                 w_ctl_next = CTL_RUN;
            CTL_RUN:  if (w_half_end && !w_more)   w_ctl_next = CTL_DONE;
            CTL_DONE:                              w_ctl_next = CTL_IDLE;
            default:                               w_ctl_next = CTL_IDLE;
        endcase
    end

    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            r_ctl           <= CTL_IDLE;
            r_last_grant    <= 1'b1;
            r_port          <= 1'b0;
            r_write         <= 1'b0;
            r_half          <= c_half_lo;
            r_addr          <= '0;
            r_data          <= '0;
            r_mask          <= '0;
            r_lo            <= '0;
            io_p0_rsp_valid <= 1'b0;
            io_p1_rsp_valid <= 1'b0;
            io_p0_rsp_data  <= '0;
            io_p1_rsp_data  <= '0;
        end else begin
            r_ctl <= w_ctl_next;
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_port       <= w_grant;
                r_write      <= w_sel_write;
                r_addr       <= w_sel_addr;
                r_data       <= w_sel_data;
                r_mask       <= w_sel_mask;
                r_half       <= w_first_half;
            end
            if (r_ctl == CTL_RUN && w_half_end && w_more) begin
                r_half <= c_half_hi;
            end
            // Only the low-half strobe lands while still running; the high
            // half is read straight from the sequencer in DONE.
            if (r_ctl == CTL_RUN && w_rd_stb) begin
                r_lo <= w_rdata;
            end
            io_p0_rsp_valid <= (r_ctl == CTL_DONE) && !r_write && !r_port;
            io_p1_rsp_valid <= (r_ctl == CTL_DONE) && !r_write &&  r_port;
            if (r_ctl == CTL_DONE && !r_write) begin
                if (r_port) begin
                    io_p1_rsp_data <= {w_rdata, r_lo};
                end else begin
                    io_p0_rsp_data <= {w_rdata, r_lo};
                end
            end
        end
    end

    sram_half_seq #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W)
    ) u_half_seq (
        .CLK              (io_mainClk),
        .reset_in         (io_resetn),
        .i_start          (w_start),
        .i_write          (w_seq_write),
        .i_addr           (w_seq_addr),
        .i_wdata          (w_seq_wdata),
        .i_be             (w_seq_be),
        .i_dat_read       (io_sram_dat_read),
        .o_half_end       (w_half_end),
        .o_rd_stb         (w_rd_stb),
        .o_rdata          (w_rdata),
        .o_sram_addr      (io_sram_addr),
        .o_sram_dat_write (io_sram_dat_write),
        .o_sram_dat_oe    (io_sram_dat_writeEnable),
        .o_sram_cs        (io_sram_cs),
        .o_sram_we        (io_sram_we),
        .o_sram_oe        (io_sram_oe),
        .o_sram_lb        (io_sram_lb),
        .o_sram_ub        (io_sram_ub)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Directed self-checking bench for sram_arbiter: one instance with
//             WAIT_CYCLES=1 on a behavioural SRAM, one with WAIT_CYCLES=3 on
//             an address-derived read pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        init_mem;
    int          errors = 0;
    int          checks = 0;

    // ---------------- instance with WAIT_CYCLES = 1 ----------------
    logic        p0_valid, p0_write, p1_valid, p1_write;
    logic [16:0] p0_addr, p1_addr;
    logic [31:0] p0_data, p1_data;
    logic [3:0]  p0_mask, p1_mask;
    logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid;
    logic [31:0] p0_rsp_data, p1_rsp_data;
    logic [17:0] s_addr;
    logic [15:0] s_rd, s_wr;
    logic        s_wen, s_cs, s_we, s_oe, s_lb, s_ub;
    logic [15:0] mem [0:1023];

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(17)) u_dut (
        .io_mainClk(clk), .io_resetn(resetn),
        .io_p0_cmd_valid(p0_valid), .io_p0_cmd_ready(p0_ready), .io_p0_cmd_write(p0_write),
        .io_p0_cmd_addr(p0_addr), .io_p0_cmd_data(p0_data), .io_p0_cmd_mask(p0_mask),
        .io_p0_rsp_valid(p0_rsp_valid), .io_p0_rsp_data(p0_rsp_data),
        .io_p1_cmd_valid(p1_valid), .io_p1_cmd_ready(p1_ready), .io_p1_cmd_write(p1_write),
        .io_p1_cmd_addr(p1_addr), .io_p1_cmd_data(p1_data), .io_p1_cmd_mask(p1_mask),
        .io_p1_rsp_valid(p1_rsp_valid), .io_p1_rsp_data(p1_rsp_data),
        .io_sram_addr(s_addr), .io_sram_dat_read(s_rd), .io_sram_dat_write(s_wr),
        .io_sram_dat_writeEnable(s_wen), .io_sram_cs(s_cs), .io_sram_we(s_we),
        .io_sram_oe(s_oe), .io_sram_lb(s_lb), .io_sram_ub(s_ub)
    );

    // Behavioural async SRAM: combinational read, byte writes while cs&we low.
    assign s_rd = mem[s_addr[9:0]];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[10'h020] <= 16'hBEEF;
            mem[10'h021] <= 16'hCAFE;
        end else if (!s_cs && !s_we) begin
            if (!s_lb) mem[s_addr[9:0]][7:0]  <= s_wr[7:0];
            if (!s_ub) mem[s_addr[9:0]][15:8] <= s_wr[15:8];
        end
    end

    // ---------------- instance with WAIT_CYCLES = 3 ----------------
    logic        q0_valid, q0_write, q1_valid, q1_write;
    logic [16:0] q0_addr, q1_addr;
    logic [31:0] q0_data, q1_data;
    logic [3:0]  q0_mask, q1_mask;
    logic        q0_ready, q1_ready, q0_rsp_valid, q1_rsp_valid;
    logic [31:0] q0_rsp_data, q1_rsp_data;
    logic [17:0] t_addr;
    logic [15:0] t_rd, t_wr;
    logic        t_wen, t_cs, t_we, t_oe, t_lb, t_ub;

    assign t_rd = t_addr[15:0] ^ 16'h5A5A;

    sram_arbiter #(.WAIT_CYCLES(3), .ADDR_W(17)) u_dut3 (
        .io_mainClk(clk), .io_resetn(resetn),
        .io_p0_cmd_valid(q0_valid), .io_p0_cmd_ready(q0_ready), .io_p0_cmd_write(q0_write),
        .io_p0_cmd_addr(q0_addr), .io_p0_cmd_data(q0_data), .io_p0_cmd_mask(q0_mask),
        .io_p0_rsp_valid(q0_rsp_valid), .io_p0_rsp_data(q0_rsp_data),
        .io_p1_cmd_valid(q1_valid), .io_p1_cmd_ready(q1_ready), .io_p1_cmd_write(q1_write),
        .io_p1_cmd_addr(q1_addr), .io_p1_cmd_data(q1_data), .io_p1_cmd_mask(q1_mask),
        .io_p1_rsp_valid(q1_rsp_valid), .io_p1_rsp_data(q1_rsp_data),
        .io_sram_addr(t_addr), .io_sram_dat_read(t_rd), .io_sram_dat_write(t_wr),
        .io_sram_dat_writeEnable(t_wen), .io_sram_cs(t_cs), .io_sram_we(t_we),
        .io_sram_oe(t_oe), .io_sram_lb(t_lb), .io_sram_ub(t_ub)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int          n, c0, c1, c2, idle_at, r0, r1;
    logic [7:0]  order;

    initial begin
        init_mem = 1'b1;
        resetn   = 1'b0;
        p0_valid = 0; p0_write = 0; p0_addr = '0; p0_data = '0; p0_mask = '0;
        p1_valid = 0; p1_write = 0; p1_addr = '0; p1_data = '0; p1_mask = '0;
        q0_valid = 0; q0_write = 0; q0_addr = '0; q0_data = '0; q0_mask = '0;
        q1_valid = 0; q1_write = 0; q1_addr = '0; q1_data = '0; q1_mask = '0;
        repeat (3) step();

        // ---- reset state ----
        chk("rst_strobes", {s_cs, s_we, s_oe, s_lb, s_ub}, 32'h1F);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_dat_write", s_wr, 32'h0);
        chk("rst_writeEnable", s_wen, 32'h0);
        chk("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 32'h0);
        chk("rst_rsp_data", p0_rsp_data | p1_rsp_data, 32'h0);
        init_mem = 1'b0;
        resetn   = 1'b1;
        step();

        // ---- p0 read of word 0x10 -> 0xCAFEBEEF after 7 cycles ----
        p0_valid = 1; p0_write = 0; p0_addr = 17'h00010;
        #1;
        chk("rd_ready", p0_ready, 32'h1);
        step();
        p0_valid = 0;
        chk("rd_setup_pins", {s_cs, s_oe, s_wen}, 32'h0);
        chk("rd_setup_addr", s_addr, 32'h20);
        chk("rd_busy_ready", p0_ready, 32'h0);
        n = 0; c1 = 0;
        while (!p0_rsp_valid && n < 20) begin
            step(); n++;
            if (p1_rsp_valid) c1++;
        end
        chk("rd_latency", n, 32'd7);
        chk("rd_data", p0_rsp_data, 32'hCAFEBEEF);
        chk("rd_other_port_quiet", c1, 32'd0);
        step();
        chk("rd_pulse_width", p0_rsp_valid, 32'h0);
        chk("rd_data_hold", p0_rsp_data, 32'hCAFEBEEF);

        // ---- p1 full write 0x12345678 to word 3 ----
        p1_valid = 1; p1_write = 1; p1_addr = 17'h3; p1_data = 32'h12345678; p1_mask = 4'hF;
        step();
        p1_valid = 0;
        c0 = 0; c1 = 0; idle_at = 0;
        for (int i = 0; i < 14; i++) begin
            if (!s_cs && !s_we && !s_lb && !s_ub && s_addr == 18'h6) c0++;
            if (!s_cs && !s_we && !s_lb && !s_ub && s_addr == 18'h7) c1++;
            if (p0_ready && idle_at == 0) idle_at = i;
            step();
        end
        chk("wr_we_low_lo", c0, 32'd2);
        chk("wr_we_low_hi", c1, 32'd2);
        chk("wr_occupancy", idle_at, 32'd9);
        chk("wr_mem_lo", mem[6], 32'h5678);
        chk("wr_mem_hi", mem[7], 32'h1234);

        // ---- p0 masked write, only byte 2 enabled ----
        p0_valid = 1; p0_write = 1; p0_addr = 17'h3; p0_data = 32'h00AA0000; p0_mask = 4'h4;
        step();
        p0_valid = 0;
        c0 = 0; c1 = 0; idle_at = 0;
        for (int i = 0; i < 10; i++) begin
            if (!s_cs && s_addr == 18'h6) c0++;
            if (!s_cs && !s_we && !s_lb && s_ub && s_addr == 18'h7) c1++;
            if (p0_ready && idle_at == 0) idle_at = i;
            step();
        end
        chk("mwr_no_lo_cycle", c0, 32'd0);
        chk("mwr_hi_lb_only", c1, 32'd2);
        chk("mwr_occupancy", idle_at, 32'd5);
        chk("mwr_mem_lo", mem[6], 32'h5678);
        chk("mwr_mem_hi", mem[7], 32'h12AA);

        // ---- reset during ACCESS of a read ----
        p0_valid = 1; p0_write = 0; p0_addr = 17'h00010; p0_mask = 4'h0;
        step();
        p0_valid = 0;
        step();
        chk("rr_in_access", {s_cs, s_lb, s_ub}, 32'h0);
        resetn = 0;
        step();
        chk("rr_strobes", {s_cs, s_we, s_oe, s_lb, s_ub}, 32'h1F);
        chk("rr_writeEnable", s_wen, 32'h0);
        resetn = 1;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 12; i++) begin
            if (p0_rsp_valid) c0++;
            if (!s_cs) c1++;
            step();
        end
        chk("rr_no_rsp", c0, 32'd0);
        chk("rr_no_cs", c1, 32'd0);

        // ---- both ports always requesting: grants alternate from p0 ----
        p0_valid = 1; p0_write = 0; p0_addr = 17'h00010;
        p1_valid = 1; p1_write = 0; p1_addr = 17'h00010;
        n = 0; c2 = 0; order = '0; r0 = 0; r1 = 0;
        while (n < 8 && c2 < 200) begin
            if (p0_ready && p1_ready) c2 = 1000;
            else if (p0_ready) begin order[n] = 1'b0; n++; end
            else if (p1_ready) begin order[n] = 1'b1; n++; end
            if (p0_rsp_valid) r0++;
            if (p1_rsp_valid) r1++;
            step(); c2++;
            if (n == 8) begin p0_valid = 0; p1_valid = 0; end
        end
        p0_valid = 0; p1_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (p0_rsp_valid) r0++;
            if (p1_rsp_valid) r1++;
            step();
        end
        chk("arb_grants", n, 32'd8);
        chk("arb_order", order, 32'hAA);
        chk("arb_rsp_p0", r0, 32'd4);
        chk("arb_rsp_p1", r1, 32'd4);
        chk("arb_p1_data", p1_rsp_data, 32'hCAFEBEEF);

        // ---- WAIT_CYCLES=3: read latency 11, 4 ACCESS cycles per half ----
        q0_valid = 1; q0_write = 0; q0_addr = 17'h5; q0_mask = 4'h0;
        step();
        q0_valid = 0;
        n = 0; c0 = 0;
        while (!q0_rsp_valid && n < 30) begin
            step(); n++;
            if (!t_cs && !t_lb) c0++;
        end
        chk("w3_latency", n, 32'd11);
        chk("w3_access_cycles", c0, 32'd8);
        chk("w3_data", q0_rsp_data, 32'h5A515A50);

        // ---- WAIT_CYCLES=3: zero-mask write touches no pins ----
        step();
        q0_valid = 1; q0_write = 1; q0_addr = 17'h9; q0_data = 32'hFFFFFFFF; q0_mask = 4'h0;
        step();
        q0_valid = 0;
        chk("w3_m0_ready_again", q0_ready, 32'h1);
        c0 = 0;
        for (int i = 0; i < 10; i++) begin
            if (!t_cs || t_wen) c0++;
            step();
        end
        chk("w3_m0_no_cs", c0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
